// File: rtl/barrel_shifter_left_pipe.sv
// Pipelined left barrel shifter, one power-of-two shift step per stage (MSB of shamt first).
// Optional build macro ROTATE_EN turns every stage into a left rotate. Requires SHW >= 2.
module barrel_shifter_left_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Stage k only needs the shamt bits still to be consumed by later stages, so the
  // leftover bits are packed into one triangular vector: stage k owns SHW-1-k bits.
  localparam int REST_W = SHW * (SHW - 1) / 2;

  function automatic int f_rest_off(input int stage);
    return stage * (SHW - 1) - (stage * (stage - 1)) / 2;
  endfunction

  function automatic logic [WIDTH-1:0] f_shift_left(input logic [WIDTH-1:0] d, input int sh);
`ifdef ROTATE_EN
    return (d << sh) | (d >> (WIDTH - sh));
`else
    return d << sh;
`endif
  endfunction

  logic [SHW-1:0]            r_valid;
  logic [SHW-1:0][WIDTH-1:0] r_data;
  logic [REST_W-1:0]         r_rest;

  logic [SHW-1:0]            w_load;
  logic [SHW-1:0]            w_src_valid;
  logic [SHW-1:0][WIDTH-1:0] w_next_data;
  logic [REST_W-1:0]         w_next_rest;
  logic [REST_W-1:0]         w_rest_mask;
  logic                      w_chain;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int RW = SHW - k;
    localparam int SH = 1 << (SHW - 1 - k);

    logic [RW-1:0]    w_sh;
    logic [WIDTH-1:0] w_d;

    if (k == 0) begin : g_src
      assign w_src_valid[k] = in_valid;
      assign w_d            = in_data;
      assign w_sh           = in_shamt;
    end else begin : g_src
      assign w_src_valid[k] = r_valid[k-1];
      assign w_d            = r_data[k-1];
      assign w_sh           = r_rest[f_rest_off(k-1) +: RW];
    end

    assign w_next_data[k] = w_sh[RW-1] ? f_shift_left(w_d, SH) : w_d;

    if (k < SHW - 1) begin : g_rest
      assign w_next_rest[f_rest_off(k) +: RW-1] = w_sh[RW-2:0];
      assign w_rest_mask[f_rest_off(k) +: RW-1] = {(RW-1){w_load[k] & w_src_valid[k]}};
    end
  end

  // Load enables ripple back from out_ready so a full, draining pipe takes a new op every cycle.
  always_comb begin
    w_load  = '0;
    w_chain = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      w_load[k] = !r_valid[k] || w_chain;
      w_chain   = w_load[k];
    end
  end

  // Stage registers; data and leftover shamt are captured only when a real op moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
      r_rest  <= '0;
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= w_src_valid[k];
          if (w_src_valid[k]) begin
            r_data[k] <= w_next_data[k];
          end
        end
      end
      r_rest <= (r_rest & ~w_rest_mask) | (w_next_rest & w_rest_mask);
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_valid[SHW-1];
  assign out_data  = r_data[SHW-1];

endmodule

// File: tb/tb_barrel_shifter_left_pipe.sv
// Self-checking bench for barrel_shifter_left_pipe: vector table, handshake sequences and
// a randomized stream scored against a whole-shift reference model.
module tb_barrel_shifter_left_pipe;
  localparam int W = 8;
  localparam int S = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [S-1:0] in_shamt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  barrel_shifter_left_pipe #(.WIDTH(W), .SHW(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [S-1:0] shamt;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[6];
  logic [W-1:0] ops[6];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           n_in = 0;
  int           n_out = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  // Whole shift in one step on a double-width value; the upper half is what fell off the MSB.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [S-1:0] sh);
    logic [2*W-1:0] wide;
    wide = {{W{1'b0}}, d} << sh;
`ifdef ROTATE_EN
    return wide[W-1:0] | wide[2*W-1:W];
`else
    return wide[W-1:0];
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge with inputs already driven; scores this cycle's transfers.
  task automatic tick();
    #1;
    if (prev_stall) begin
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_out_data", out_data, prev_data);
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
      else check("result_order", out_data, exp_q.pop_front());
    end
    if (in_valid && in_ready) begin
      n_in++;
      exp_q.push_back(ref_shift(in_data, in_shamt));
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int base;
    int start_in;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_shamt = '0;

`ifdef ROTATE_EN
    vecs[0] = '{8'b1011_0011, 3'd3, 8'b1001_1101};
    vecs[3] = '{8'h80, 3'd1, 8'h01};
    vecs[4] = '{8'hFF, 3'd4, 8'hFF};
    vecs[5] = '{8'h5A, 3'd5, 8'h4B};
`else
    vecs[0] = '{8'b1011_0011, 3'd3, 8'b1001_1000};
    vecs[3] = '{8'h80, 3'd1, 8'h00};
    vecs[4] = '{8'hFF, 3'd4, 8'hF0};
    vecs[5] = '{8'h5A, 3'd5, 8'h40};
`endif
    vecs[1] = '{8'hA5, 3'd0, 8'hA5};
    vecs[2] = '{8'h01, 3'd7, 8'h80};
    for (int i = 0; i < 6; i++) ops[i] = 8'(8'h11 * (i + 1));

    repeat (2) @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 8'h00);
    rst_n = 1'b1;
    #1 check("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Directed vectors: single op, latency and value
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = vecs[i].data; in_shamt = vecs[i].shamt; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      waited = 0;
      while (!out_valid && waited < 10) begin
        tick();
        waited++;
      end
      check($sformatf("vec%0d_latency", i), waited, S - 1);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      tick();
    end
    drain();

    // Four back-to-back ops: out_valid high for exactly cycles 3..6
    for (int t = 0; t < 8; t++) begin
      in_valid = (t < 4); in_data = W'($urandom); in_shamt = S'($urandom); out_ready = 1'b1;
      #1 check($sformatf("b2b_out_valid_t%0d", t), out_valid, (t >= 3 && t <= 6));
      tick();
    end
    drain();

    // Backpressure: six ops, out_ready low for five cycles
    base = n_out;
    start_in = n_in;
    for (int t = 0; t < 40; t++) begin
      if (n_in - start_in >= 6 && t >= 5) break;
      in_valid  = (n_in - start_in) < 6;
      in_data   = ops[(n_in - start_in) < 6 ? (n_in - start_in) : 5];
      in_shamt  = S'(t);
      out_ready = (t >= 5);
      #1;
      if (t < 5) check($sformatf("bp_in_ready_t%0d", t), in_ready, (t < 3));
      tick();
    end
    drain();
    check("bp_result_count", n_out - base, 6);

    // Reset with ops in flight
    in_valid = 1'b1; out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      in_data = W'($urandom); in_shamt = S'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #1 check("pre_reset_out_valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid, 1'b0);
    check("async_reset_out_data", out_data, 8'h00);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      out_ready = 1'b1;
      #1;
      check($sformatf("post_reset_in_ready_t%0d", t), in_ready, 1'b1);
      check($sformatf("post_reset_no_stale_t%0d", t), out_valid, 1'b0);
      tick();
    end

    // Full pipe streaming: one result per cycle, in_ready stays high
    in_valid = 1'b1; out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      in_data = W'($urandom); in_shamt = S'($urandom);
      tick();
    end
    base = n_out;
    for (int t = 0; t < 10; t++) begin
      in_valid = 1'b1; in_data = W'($urandom); in_shamt = S'($urandom); out_ready = 1'b1;
      #1;
      check($sformatf("full_in_ready_t%0d", t), in_ready, 1'b1);
      check($sformatf("full_out_valid_t%0d", t), out_valid, 1'b1);
      tick();
    end
    check("full_rate_count", n_out - base, 10);
    drain();

    // Randomized stream with random stalls
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      in_shamt  = S'($urandom);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
